mcpu_prog_loader: RTL and testbench
===================================

MCPU_PROG_LOADER -- requirements
Module: mcpu_prog_loader

Interface
REQ-001 Parameter WORD_SIZE, default 16: width of one instruction/data word.
REQ-002 Parameter ADDR_SIZE, default 8: width of the memory address.
REQ-003 Parameter RAM_SIZE, default 256: number of loadable words; SHALL satisfy RAM_SIZE <= 2**ADDR_SIZE.
REQ-004 Port clk, input, 1: single clock, rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port start, input, 1: one-cycle request to begin a load.
REQ-007 Port prog_len, input, ADDR_SIZE+1: number of words to load, sampled at an accepted start.
REQ-008 Port clear_rest, input, 1: zero-fill the rest of memory after the load, sampled at an accepted start.
REQ-009 Port in_data, input, WORD_SIZE: program word stream.
REQ-010 Port in_valid, input, 1: in_data is valid.
REQ-011 Port in_ready, output, 1: loader accepts a word this cycle.
REQ-012 Port mem_we, output, 1: RAM write strobe.
REQ-013 Port mem_addr, output, ADDR_SIZE: RAM write address.
REQ-014 Port mem_wdata, output, WORD_SIZE: RAM write data.
REQ-015 Port cpu_hold, output, 1: high holds the MCPU in reset.
REQ-016 Port busy, output, 1: high in LOAD or CLEAR.
REQ-017 Port done, output, 1: one-cycle pulse when the load completes.
REQ-018 Port checksum, output, WORD_SIZE: sum of the loaded words.
REQ-019 Port err, output, 1: sticky error flag.

Function
REQ-020 The FSM SHALL have four states, IDLE, LOAD, CLEAR and RUN; all outputs SHALL be registered.
REQ-021 A start in IDLE or RUN with 1 <= prog_len <= RAM_SIZE SHALL be accepted:
- next state LOAD
- address counter and checksum cleared
- cpu_hold=1
- err cleared
REQ-022 A start with prog_len==0 or prog_len>RAM_SIZE SHALL set err=1 and leave the state unchanged.
REQ-023 A start while busy=1 SHALL set err=1 and be otherwise ignored.
REQ-024 In LOAD, in_ready SHALL be 1; in every other state it SHALL be 0.
REQ-025 A beat SHALL transfer only on a cycle where in_valid && in_ready; in_valid low stalls the load without limit.
REQ-026 Each accepted beat SHALL produce, exactly one cycle later:
- mem_we=1
- mem_addr=counter
- mem_wdata=in_data
- checksum += in_data, modulo 2**WORD_SIZE
REQ-027 The counter SHALL increment per accepted beat.
REQ-028 On the beat with counter==prog_len-1, in_ready SHALL drop the following cycle and the FSM SHALL go to:
- CLEAR, if clear_rest=1 and prog_len<RAM_SIZE
- RUN, otherwise
REQ-029 In CLEAR, the block SHALL write 0 to addresses prog_len..RAM_SIZE-1, one per cycle, in ascending order, then go to RUN; checksum SHALL be unaffected.
REQ-030 On entry to RUN, done SHALL pulse for exactly one cycle and cpu_hold SHALL go to 0 in the same cycle; checksum SHALL then hold until the next accepted start.
REQ-031 mem_we SHALL be 0 in IDLE and RUN, and in any LOAD cycle not following an accepted beat.
REQ-032 The counter SHALL never wrap; prog_len=RAM_SIZE SHALL end the load at address RAM_SIZE-1 and skip CLEAR.

Reset
REQ-033 While reset=0, the block SHALL be in IDLE with:
- cpu_hold=1
- in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0
- busy=0, done=0, checksum=0, err=0
REQ-034 Reset asserted mid-LOAD or mid-CLEAR SHALL abort immediately; partially written RAM is not restored.

Structure
REQ-035 WORD_SIZE and ADDR_SIZE defaults and the state enumeration SHALL live in the shared mcpu_pkg alongside the existing opcode constants.
REQ-036 The block SHALL be a single module; no sub-module is warranted.

Verification
REQ-037 Load of 3 words 0x1000,0x1101,0x1202 with clear_rest=1 -> writes to addresses 0..2, then 253 zero writes to 3..255, done pulse, cpu_hold=0, checksum=0x3303.
REQ-038 Same load with clear_rest=0 and in_valid low for 4 cycles between beats -> exactly 3 writes, in_ready stays 1 during the stall, checksum=0x3303.
REQ-039 prog_len=256 with words 0..255 -> last write at address 255, no CLEAR, checksum=0x7F80.
REQ-040 prog_len=0, then prog_len=257, then start during LOAD -> err=1 each time, state and counter unchanged.
REQ-041 reset=0 after 2 beats of a 5-word load -> all outputs at their reset values, cpu_hold=1; a fresh start loads from address 0.
REQ-042 start from RUN with prog_len=1 and word 0xFFFF -> cpu_hold back to 1, one write to address 0, checksum=0xFFFF.

Source files
------------

// File: rtl/mcpu_pkg.sv
// Shared MCPU definitions: word/address widths, opcodes and loader states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mcpu_pkg;

    localparam int MCPU_WORD_SIZE = 16;
    localparam int MCPU_ADDR_SIZE = 8;

    // MCPU opcodes, upper nibble of an instruction word
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JZ  = 4'h6;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Program loader FSM states
    typedef enum logic [1:0] {
        LDR_IDLE  = 2'd0,
        LDR_LOAD  = 2'd1,
        LDR_CLEAR = 2'd2,
        LDR_RUN   = 2'd3
    } ldr_state_e;

endpackage : mcpu_pkg

// File: rtl/mcpu_prog_loader_if.sv
// Program word stream (valid/ready) plus the RAM write port of the loader.
// Latency: n/a (wiring only).
// Backpressure: in_ready from the loader throttles the word source.
interface mcpu_prog_loader_if #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 8
) ();

    logic [WORD_SIZE-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 mem_we;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;

    // Loader side: consumes the word stream, drives the RAM write port
    modport loader (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    // Host side: produces the word stream, observes the RAM write port
    modport host (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

endinterface : mcpu_prog_loader_if

// File: rtl/mcpu_prog_loader.sv
// Loads a program stream into MCPU RAM, optionally zero-fills the rest, then releases the CPU.
// Latency: each accepted word is written to RAM one cycle after its beat; all outputs registered.
// Backpressure: in_ready is high for the whole LOAD state; in_valid low stalls indefinitely.
module mcpu_prog_loader
    import mcpu_pkg::*;
#(
    parameter int WORD_SIZE = MCPU_WORD_SIZE,
    parameter int ADDR_SIZE = MCPU_ADDR_SIZE,
    parameter int RAM_SIZE  = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_SIZE:0]   prog_len,
    input  logic                 clear_rest,
    mcpu_prog_loader_if.loader   bus,
    output logic                 cpu_hold,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] checksum,
    output logic                 err
);

    // Counter is one bit wider than the address so it can hold RAM_SIZE itself
    localparam logic [ADDR_SIZE:0] RAM_LEN   = (ADDR_SIZE+1)'(RAM_SIZE);
    localparam logic [ADDR_SIZE:0] LAST_ADDR = (ADDR_SIZE+1)'(RAM_SIZE - 1);
    localparam logic [ADDR_SIZE:0] CNT_ONE   = (ADDR_SIZE+1)'(1);

    ldr_state_e           state_q,     state_d;
    logic [ADDR_SIZE:0]   cnt_q,       cnt_d;
    logic [ADDR_SIZE:0]   len_q,       len_d;
    logic                 clr_q,       clr_d;
    logic                 in_ready_q,  in_ready_d;
    logic                 mem_we_q,    mem_we_d;
    logic [ADDR_SIZE-1:0] mem_addr_q,  mem_addr_d;
    logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic                 cpu_hold_q,  cpu_hold_d;
    logic                 busy_q,      busy_d;
    logic                 done_q,      done_d;
    logic [WORD_SIZE-1:0] checksum_q,  checksum_d;
    logic                 err_q,       err_d;

    logic len_ok;
    logic beat;
    logic last_beat;

    assign len_ok    = (prog_len != '0) && (prog_len <= RAM_LEN);
    assign beat      = bus.in_valid && in_ready_q;
    assign last_beat = (cnt_q == (len_q - CNT_ONE));

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        clr_d       = clr_q;
        in_ready_d  = in_ready_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        checksum_d  = checksum_q;
        err_d       = err_q;

        unique case (state_q)
            LDR_IDLE, LDR_RUN: begin
                if (start) begin
                    if (len_ok) begin
                        state_d    = LDR_LOAD;
                        cnt_d      = '0;
                        len_d      = prog_len;
                        clr_d      = clear_rest;
                        checksum_d = '0;
                        cpu_hold_d = 1'b1;
                        busy_d     = 1'b1;
                        in_ready_d = 1'b1;
                        err_d      = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            LDR_LOAD: begin
                if (start) begin
                    err_d = 1'b1;
                end
                if (beat) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cnt_q[ADDR_SIZE-1:0];
                    mem_wdata_d = bus.in_data;
                    checksum_d  = checksum_q + bus.in_data;
                    cnt_d       = cnt_q + CNT_ONE;
                    if (last_beat) begin
                        in_ready_d = 1'b0;
                        if (clr_q && (len_q < RAM_LEN)) begin
                            state_d = LDR_CLEAR;
                        end else begin
                            // Final write lands in the first RUN cycle alongside done
                            state_d    = LDR_RUN;
                            busy_d     = 1'b0;
                            done_d     = 1'b1;
                            cpu_hold_d = 1'b0;
                        end
                    end
                end
            end

            LDR_CLEAR: begin
                if (start) begin
                    err_d = 1'b1;
                end
                // Counter already points at prog_len on entry
                mem_we_d    = 1'b1;
                mem_addr_d  = cnt_q[ADDR_SIZE-1:0];
                mem_wdata_d = '0;
                cnt_d       = cnt_q + CNT_ONE;
                if (cnt_q == LAST_ADDR) begin
                    state_d    = LDR_RUN;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
                end
            end

            default: begin
                state_d = LDR_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any load in progress
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= LDR_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            clr_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            checksum_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            clr_q       <= clr_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            checksum_q  <= checksum_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign cpu_hold      = cpu_hold_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign checksum      = checksum_q;
    assign err           = err_q;

endmodule : mcpu_prog_loader

// File: tb/tb_mcpu_prog_loader.sv
// Directed bench for mcpu_prog_loader: clear-fill, stalls, full load, errors, reset abort, reload.
// Latency: checks expect each write one cycle after its beat.
// Backpressure: stimulus holds in_valid low to stall loads.
module tb_mcpu_prog_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [8:0]  prog_len;
    logic        clear_rest;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic [15:0] checksum;
    logic        err;

    int n_checks;
    int n_fail;

    logic [7:0]  wa_q[$];
    logic [15:0] wd_q[$];

    mcpu_prog_loader_if #(.WORD_SIZE(16), .ADDR_SIZE(8)) bus ();

    mcpu_prog_loader #(.WORD_SIZE(16), .ADDR_SIZE(8), .RAM_SIZE(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .prog_len   (prog_len),
        .clear_rest (clear_rest),
        .bus        (bus),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every RAM write seen on the port
    always @(negedge clk) begin
        if (bus.mem_we) begin
            wa_q.push_back(bus.mem_addr);
            wd_q.push_back(bus.mem_wdata);
        end
    end

    task automatic do_start(input logic [8:0] len, input logic clr);
        start      = 1'b1;
        prog_len   = len;
        clear_rest = clr;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #23;
        n_checks++;
        if ({cpu_hold, bus.in_ready, bus.mem_we, busy, done, err} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 100000",
                     {cpu_hold, bus.in_ready, bus.mem_we, busy, done, err});
        end
        n_checks++;
        if ({bus.mem_addr, bus.mem_wdata, checksum} !== 40'h0) begin
            n_fail++;
            $display("FAIL reset_buses: got %h expected 0", {bus.mem_addr, bus.mem_wdata, checksum});
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_clear;
        bit got;
        bit bad;
        wa_q.delete(); wd_q.delete();
        do_start(9'd3, 1'b1);
        send_word(16'h1000);
        send_word(16'h1101);
        send_word(16'h1202);
        wait_done(400, got);
        n_checks++;
        if (got !== 1'b1 || cpu_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_done: done=%b cpu_hold=%b expected done=1 cpu_hold=0", got, cpu_hold);
        end
        n_checks++;
        if (checksum !== 16'h3303) begin
            n_fail++;
            $display("FAIL clr_checksum: got %h expected 3303", checksum);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || bus.mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_pulse: done=%b mem_we=%b expected 0 0", done, bus.mem_we);
        end
        n_checks++;
        if (wa_q.size() != 256) begin
            n_fail++;
            $display("FAIL clr_count: got %0d writes expected 256", wa_q.size());
        end
        bad = 1'b0;
        for (int i = 0; i < wa_q.size(); i++) begin
            if (wa_q[i] != i[7:0]) bad = 1'b1;
            if (i == 0 && wd_q[i] != 16'h1000) bad = 1'b1;
            if (i == 1 && wd_q[i] != 16'h1101) bad = 1'b1;
            if (i == 2 && wd_q[i] != 16'h1202) bad = 1'b1;
            if (i >= 3 && wd_q[i] != 16'h0000) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_contents: got bad=%b expected ordered 0..255 with data 1000,1101,1202,0...", bad);
        end
    endtask

    task automatic test_stall;
        bit got;
        bit rdy_ok;
        wa_q.delete(); wd_q.delete();
        do_start(9'd3, 1'b0);
        n_checks++;
        if (cpu_hold !== 1'b1 || checksum !== 16'h0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_accept: cpu_hold=%b checksum=%h busy=%b expected 1 0000 1",
                     cpu_hold, checksum, busy);
        end
        rdy_ok = 1'b1;
        send_word(16'h1000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.in_ready !== 1'b1) rdy_ok = 1'b0;
        end
        @(posedge clk); #1;
        send_word(16'h1101);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.in_ready !== 1'b1) rdy_ok = 1'b0;
        end
        @(posedge clk); #1;
        send_word(16'h1202);
        n_checks++;
        if (rdy_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_ready: got ready_held=%b expected 1", rdy_ok);
        end
        wait_done(10, got);
        @(negedge clk);
        n_checks++;
        if (got !== 1'b1 || wa_q.size() != 3) begin
            n_fail++;
            $display("FAIL stall_writes: done=%b writes=%0d expected 1 3", got, wa_q.size());
        end else begin
            n_checks++;
            if ({wa_q[0], wa_q[1], wa_q[2], wd_q[0], wd_q[1], wd_q[2]} !== 72'h000102_1000_1101_1202) begin
                n_fail++;
                $display("FAIL stall_data: got %h %h %h / %h %h %h expected 00 01 02 / 1000 1101 1202",
                         wa_q[0], wa_q[1], wa_q[2], wd_q[0], wd_q[1], wd_q[2]);
            end
        end
        n_checks++;
        if (checksum !== 16'h3303) begin
            n_fail++;
            $display("FAIL stall_checksum: got %h expected 3303", checksum);
        end
    endtask

    task automatic test_full;
        bit got;
        bit bad;
        wa_q.delete(); wd_q.delete();
        do_start(9'd256, 1'b1);
        for (int i = 0; i < 256; i++) send_word(16'(i));
        wait_done(2, got);
        n_checks++;
        if (got !== 1'b1 || checksum !== 16'h7F80) begin
            n_fail++;
            $display("FAIL full_done: done=%b checksum=%h expected 1 7f80", got, checksum);
        end
        @(negedge clk);
        bad = (wa_q.size() != 256);
        for (int i = 0; i < wa_q.size(); i++) begin
            if (wa_q[i] != i[7:0] || wd_q[i] != i[15:0]) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0 || wa_q[$] !== 8'hFF) begin
            n_fail++;
            $display("FAIL full_writes: bad=%b writes=%0d last=%h expected 0 256 ff",
                     bad, wa_q.size(), wa_q[$]);
        end
    endtask

    task automatic test_errors;
        bit got;
        wa_q.delete(); wd_q.delete();
        do_start(9'd0, 1'b0);
        n_checks++;
        if ({err, cpu_hold, busy, bus.in_ready} !== 4'b1000) begin
            n_fail++;
            $display("FAIL err_len0: got %b expected err=1 hold=0 busy=0 rdy=0",
                     {err, cpu_hold, busy, bus.in_ready});
        end
        do_start(9'd257, 1'b0);
        n_checks++;
        if ({err, cpu_hold, busy, bus.in_ready} !== 4'b1000) begin
            n_fail++;
            $display("FAIL err_len257: got %b expected err=1 hold=0 busy=0 rdy=0",
                     {err, cpu_hold, busy, bus.in_ready});
        end
        do_start(9'd2, 1'b0);
        n_checks++;
        if ({err, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL err_clear: got err=%b busy=%b expected 0 1", err, busy);
        end
        send_word(16'h0042);
        do_start(9'd1, 1'b0);
        n_checks++;
        if ({err, busy, bus.in_ready, done} !== 4'b1110) begin
            n_fail++;
            $display("FAIL err_busy: got %b expected err=1 busy=1 rdy=1 done=0",
                     {err, busy, bus.in_ready, done});
        end
        send_word(16'h0043);
        wait_done(3, got);
        @(negedge clk);
        n_checks++;
        if (got !== 1'b1 || wa_q.size() != 2 || wa_q[1] !== 8'h01 || checksum !== 16'h0085) begin
            n_fail++;
            $display("FAIL err_counter: done=%b writes=%0d checksum=%h expected 1 2 0085",
                     got, wa_q.size(), checksum);
        end
    endtask

    task automatic test_reset_mid;
        bit got;
        do_start(9'd5, 1'b0);
        send_word(16'h1111);
        send_word(16'h2222);
        reset = 1'b0;
        #2;
        n_checks++;
        if ({cpu_hold, bus.in_ready, bus.mem_we, busy, done, err} !== 6'b100000 ||
            {bus.mem_addr, bus.mem_wdata, checksum} !== 40'h0) begin
            n_fail++;
            $display("FAIL abort_outputs: flags=%b buses=%h expected 100000 0",
                     {cpu_hold, bus.in_ready, bus.mem_we, busy, done, err},
                     {bus.mem_addr, bus.mem_wdata, checksum});
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        wa_q.delete(); wd_q.delete();
        do_start(9'd1, 1'b0);
        send_word(16'hABCD);
        wait_done(3, got);
        @(negedge clk);
        n_checks++;
        if (got !== 1'b1 || wa_q.size() != 1 || wa_q[0] !== 8'h00 || wd_q[0] !== 16'hABCD) begin
            n_fail++;
            $display("FAIL abort_reload: done=%b writes=%0d expected 1 write of abcd at 00", got, wa_q.size());
        end
    endtask

    task automatic test_back_to_back;
        bit got;
        wa_q.delete(); wd_q.delete();
        do_start(9'd1, 1'b0);
        n_checks++;
        if (cpu_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL rerun_hold: got %b expected 1", cpu_hold);
        end
        send_word(16'hFFFF);
        wait_done(3, got);
        n_checks++;
        if (got !== 1'b1 || checksum !== 16'hFFFF || cpu_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL rerun_done: done=%b checksum=%h hold=%b expected 1 ffff 0", got, checksum, cpu_hold);
        end
        @(negedge clk);
        n_checks++;
        if (wa_q.size() != 1 || wa_q[0] !== 8'h00 || wd_q[0] !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL rerun_write: writes=%0d expected 1 write of ffff at 00", wa_q.size());
        end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        start        = 1'b0;
        prog_len     = '0;
        clear_rest   = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        test_reset();
        test_load_clear();
        test_stall();
        test_full();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mcpu_prog_loader
